// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES job arbiter: FSM states, block
// pack/unpack between the flat 128-bit bus and the byte matrix, counter widths.
package aes_ctrl_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned CED_W   = 6;
  localparam int unsigned TIMER_W = 6;
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CHECK,
    ST_RESP
  } state_e;

  // Byte [r][c] of the AES state sits at bits [8*(4*r+c)+:8] of the flat bus
  typedef logic [3:0][3:0][7:0] aes_state_t;

  function automatic aes_state_t unpack_block(input logic [BLOCK_W-1:0] v);
    aes_state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = v[8*(4*r+c) +: 8];
    return s;
  endfunction

  function automatic logic [BLOCK_W-1:0] pack_block(input aes_state_t s);
    logic [BLOCK_W-1:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[8*(4*r+c) +: 8] = s[r][c];
    return v;
  endfunction

endpackage

// File: rtl/aes_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one iterative aes_128 core among NUM_REQ requesters: round-robin grant,
// launch, retry on detected fault, timeout abort, single response channel.
module aes_job_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = $clog2(NUM_REQ),
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_data,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_key,
  input  logic [NUM_REQ*CED_W-1:0]   req_ced,
  output logic                       core_reset,
  output logic [BLOCK_W-1:0]         core_data,
  output logic [BLOCK_W-1:0]         core_key,
  output logic [1:0]                 core_ced,
  output logic [3:0]                 core_ced_rnd,
  input  logic [BLOCK_W-1:0]         core_ct,
  input  logic                       core_done,
  input  logic                       core_fault,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [BLOCK_W-1:0]         rsp_data,
  output logic                       rsp_fault,
  output logic                       rsp_timeout,
  output logic [RETRY_W-1:0]         rsp_retries
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      job_id;
  logic [TIMER_W-1:0]   timer;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [BLOCK_W-1:0]   ct_q;
  logic                 fault_q;
  logic                 timeout_hit;
  logic                 retry_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Grant is only offered while idle and never during reset
  assign req_ready   = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign timeout_hit = (timer == TIMER_W'(TIMEOUT - 1));
  assign retry_ok    = fault_q && (retry_cnt < RETRY_W'(MAX_RETRY));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant_any) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN: begin
        if (core_done)        state_d = ST_CHECK;
        else if (timeout_hit) state_d = ST_RESP;
      end
      ST_CHECK: state_d = retry_ok ? ST_LOAD : ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Job latch, core drive, run bookkeeping and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      job_id       <= '0;
      core_reset   <= 1'b1;
      core_data    <= '0;
      core_key     <= '0;
      core_ced     <= '0;
      core_ced_rnd <= '0;
      timer        <= '0;
      retry_cnt    <= '0;
      ct_q         <= '0;
      fault_q      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_fault    <= 1'b0;
      rsp_timeout  <= 1'b0;
      rsp_retries  <= '0;
    end else begin
      core_reset <= (state_d != ST_RUN);
      unique case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            core_data                <= req_data[BLOCK_W*int'(grant_idx) +: BLOCK_W];
            core_key                 <= req_key[BLOCK_W*int'(grant_idx) +: BLOCK_W];
            {core_ced, core_ced_rnd} <= req_ced[CED_W*int'(grant_idx) +: CED_W];
            job_id                   <= grant_idx;
            ptr       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            retry_cnt <= '0;
          end
        end
        ST_LOAD: timer <= '0;
        ST_RUN: begin
          timer <= timer + TIMER_W'(1);
          if (core_done) begin
            ct_q    <= core_ct;
            fault_q <= core_fault;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= job_id;
            rsp_data    <= '0;
            rsp_fault   <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_retries <= retry_cnt;
          end
        end
        ST_CHECK: begin
          if (retry_ok) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
          end else begin
            rsp_valid   <= 1'b1;
            rsp_id      <= job_id;
            rsp_data    <= ct_q;
            rsp_fault   <= fault_q;
            rsp_timeout <= 1'b0;
            rsp_retries <= retry_cnt;
          end
        end
        ST_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
